ld_ext_unit: RTL and testbench

Load-data alignment and extension unit for the memory stage. It generalises byte-enable load extension to a parametrised bus width and adds a sequential, handshaked path that fetches one or two memory words per load. Each load is byte, half, word or (64-bit bus only) doubleword, at any byte offset, sign- or zero-extended. The unit sits between the load issue logic and the data memory port, and returns one extended result per request.

---
 rtl/ld_ext_pkg.sv | 19 +
 rtl/ld_ext_extract.sv | 41 ++++
 rtl/ld_ext_unit.sv | 172 +++++++++++++++++
 tb/tb_ld_ext_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ld_ext_pkg.sv
// Shared types and helpers for the load alignment/extension unit.
package ld_ext_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_WT0,
    ST_RD1,
    ST_WT1,
    ST_OUT
  } state_e;

  function automatic logic [3:0] bytes_of(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/ld_ext_extract.sv
// Combinational shift, mask and sign/zero extension of a {hi,lo} bus-word pair.
module ld_ext_extract
  import ld_ext_pkg::*;
#(
  parameter int DW = 32,
  localparam int OW = $clog2(DW/8)
) (
  input  logic [DW-1:0] lo,
  input  logic [DW-1:0] hi,
  input  logic [OW-1:0] off,
  input  logic [1:0]    size,
  input  logic          zext,
  output logic [DW-1:0] data
);

  logic [2*DW-1:0] shifted;
  logic            sign;
  logic            fill;
  logic [DW/8-1:0] keep;

  assign shifted = {hi, lo} >> {off, 3'b000};

  always_comb begin
    sign = 1'b0;
    case (size)
      SZ_B:    sign = shifted[7];
      SZ_H:    sign = shifted[15];
      SZ_W:    sign = shifted[31];
      default: sign = shifted[63];
    endcase
  end

  assign fill = ~zext & sign;

  // Byte lanes inside the field pass through; lanes above it take the fill bit.
  for (genvar gi = 0; gi < DW/8; gi++) begin : g_lane
    assign keep[gi]          = 4'(gi) < bytes_of(size);
    assign data[gi*8 +: 8]   = keep[gi] ? shifted[gi*8 +: 8] : {8{fill}};
  end

endmodule

// File: rtl/ld_ext_unit.sv
// Handshaked load alignment/extension unit; optional split-access support via MISALIGN_EN.
module ld_ext_unit
  import ld_ext_pkg::*;
#(
  parameter int DW = 32,
  localparam int OW = $clog2(DW/8)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [OW-1:0] req_off,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  output logic          mem_rd_valid,
  input  logic          mem_rd_ready,
  output logic          mem_rd_second,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rsp_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_err
);

  state_e        state_reg, state_next;
  logic [OW-1:0] off_reg;
  logic [1:0]    size_reg;
  logic          uns_reg;
  logic [DW-1:0] lo_reg;
  logic [DW-1:0] out_data_reg;
  logic          out_err_reg;
  logic [DW-1:0] ext_lo, ext_hi, ext_data;
  logic [4:0]    end_byte;
  logic          req_split, req_illegal, req_err, accept;

  assign end_byte    = 5'(req_off) + 5'(bytes_of(req_size));
  assign req_split   = end_byte > 5'(DW/8);
  assign req_illegal = (req_size == SZ_D) && (DW == 32);
  assign accept      = req_valid && (state_reg == ST_IDLE);

`ifdef MISALIGN_EN
  logic          split_reg;
  logic [DW-1:0] hi_reg;
  assign req_err = req_illegal;
`else
  assign req_err = req_illegal || req_split;
`endif

  // The beat arriving this cycle is fed straight in so the result can be registered on entry to OUT.
  always_comb begin
    ext_lo = (state_reg == ST_WT0) ? mem_rsp_data : lo_reg;
`ifdef MISALIGN_EN
    ext_hi = (state_reg == ST_WT1) ? mem_rsp_data : hi_reg;
`else
    ext_hi = '0;
`endif
  end

  ld_ext_extract #(.DW(DW)) u_extract (
    .lo   (ext_lo),
    .hi   (ext_hi),
    .off  (off_reg),
    .size (size_reg),
    .zext (uns_reg),
    .data (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    req_ready     = 1'b0;
    mem_rd_valid  = 1'b0;
    mem_rd_second = 1'b0;
    out_valid     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_err ? ST_OUT : ST_RD0;
      end
      ST_RD0: begin
        mem_rd_valid = 1'b1;
        if (mem_rd_ready) state_next = ST_WT0;
      end
      ST_WT0: begin
`ifdef MISALIGN_EN
        if (mem_rsp_valid) state_next = split_reg ? ST_RD1 : ST_OUT;
`else
        if (mem_rsp_valid) state_next = ST_OUT;
`endif
      end
`ifdef MISALIGN_EN
      ST_RD1: begin
        mem_rd_valid  = 1'b1;
        mem_rd_second = 1'b1;
        if (mem_rd_ready) state_next = ST_WT1;
      end
      ST_WT1: begin
        if (mem_rsp_valid) state_next = ST_OUT;
      end
`endif
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_reg      <= '0;
      size_reg     <= '0;
      uns_reg      <= 1'b0;
      lo_reg       <= '0;
      out_data_reg <= '0;
      out_err_reg  <= 1'b0;
    end else begin
      if (accept) begin
        off_reg  <= req_off;
        size_reg <= req_size;
        uns_reg  <= req_unsigned;
        lo_reg   <= '0;
        if (req_err) begin
          out_err_reg  <= 1'b1;
          out_data_reg <= '0;
        end
      end
      if (state_reg == ST_WT0 && mem_rsp_valid) begin
        lo_reg <= mem_rsp_data;
`ifdef MISALIGN_EN
        if (!split_reg) begin
          out_data_reg <= ext_data;
          out_err_reg  <= 1'b0;
        end
`else
        out_data_reg <= ext_data;
        out_err_reg  <= 1'b0;
`endif
      end
`ifdef MISALIGN_EN
      if (state_reg == ST_WT1 && mem_rsp_valid) begin
        out_data_reg <= ext_data;
        out_err_reg  <= 1'b0;
      end
`endif
    end
  end

`ifdef MISALIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split_reg <= 1'b0;
      hi_reg    <= '0;
    end else begin
      if (accept) begin
        split_reg <= req_split;
        hi_reg    <= '0;
      end
      if (state_reg == ST_WT1 && mem_rsp_valid) hi_reg <= mem_rsp_data;
    end
  end
`endif

  assign out_data = out_data_reg;
  assign out_err  = out_err_reg;

endmodule

// File: tb/tb_ld_ext_unit.sv
// Randomised bench for ld_ext_unit at DW=32 and DW=64 against a byte-level reference model.
module tb_ld_ext_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [2:0]  req_off;
  logic        mem_rd_ready, mem_rsp_valid, out_ready;
  logic [63:0] mem_rsp_data;
  logic        req_valid_a, req_valid_b;

  logic        req_ready_a, mem_rd_valid_a, mem_rd_second_a, out_valid_a, out_err_a;
  logic [31:0] out_data_a;
  logic        req_ready_b, mem_rd_valid_b, mem_rd_second_b, out_valid_b, out_err_b;
  logic [63:0] out_data_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ld_ext_unit #(.DW(32)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_off(req_off[1:0]), .req_size(req_size), .req_unsigned(req_unsigned),
    .mem_rd_valid(mem_rd_valid_a), .mem_rd_ready(mem_rd_ready), .mem_rd_second(mem_rd_second_a),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data[31:0]),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_err(out_err_a)
  );

  ld_ext_unit #(.DW(64)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_off(req_off), .req_size(req_size), .req_unsigned(req_unsigned),
    .mem_rd_valid(mem_rd_valid_b), .mem_rd_ready(mem_rd_ready), .mem_rd_second(mem_rd_second_b),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_err(out_err_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic obs_rr(input bit sel);   return sel ? req_ready_b     : req_ready_a;     endfunction
  function automatic logic obs_rdv(input bit sel);  return sel ? mem_rd_valid_b  : mem_rd_valid_a;  endfunction
  function automatic logic obs_sec(input bit sel);  return sel ? mem_rd_second_b : mem_rd_second_a; endfunction
  function automatic logic obs_ov(input bit sel);   return sel ? out_valid_b     : out_valid_a;     endfunction
  function automatic logic obs_err(input bit sel);  return sel ? out_err_b       : out_err_a;       endfunction
  function automatic logic [63:0] obs_od(input bit sel);
    return sel ? out_data_b : {32'h0, out_data_a};
  endfunction

  // Reference: gather the addressed bytes one at a time, then extend with plain arithmetic.
  function automatic void model(input int dw, input int off, input int size, input bit zext,
                                input logic [63:0] w0, input logic [63:0] w1,
                                output logic [63:0] data, output bit err, output int nreads);
    int nb, wb, idx;
    bit split;
    logic [63:0] v, b;
    nb = 1 << size;
    wb = dw / 8;
    split = (off + nb) > wb;
    data = 64'h0;
    err = 1'b0;
    nreads = 0;
    v = 64'h0;
    if (size == 3 && dw == 32) begin
      err = 1'b1;
      return;
    end
    if (split) begin
`ifdef MISALIGN_EN
      nreads = 2;
`else
      err = 1'b1;
      return;
`endif
    end else begin
      nreads = 1;
    end
    for (int i = 0; i < nb; i++) begin
      idx = off + i;
      b = (idx < wb) ? 64'(w0[idx*8 +: 8]) : 64'(w1[(idx-wb)*8 +: 8]);
      v = v | (b << (8*i));
    end
    if (!zext && v[nb*8-1]) v = v | ~((64'd1 << (nb*8)) - 64'd1);
    data = (dw == 32) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  task automatic run_load(input bit sel, input int off, input int size, input bit zext,
                          input logic [63:0] w0, input logic [63:0] w1,
                          input int srd, input int srsp, input int sout, input string tag);
    logic [63:0] exp_d, held, rsp_cur;
    bit exp_e, done, rr_ok, stable_ok, held_err;
    int exp_reads, reads, cyc, lat, rd_w, rsp_w, out_w, exp_lat;
    bit rsp_pend;
    logic [1:0] secs;
    model(sel ? 64 : 32, off, size, zext, w0, w1, exp_d, exp_e, exp_reads);
    check({tag, "_ready_before"}, obs_rr(sel), 1'b1);
    req_off = 3'(off);
    req_size = 2'(size);
    req_unsigned = zext;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_off = 3'($urandom);
    req_size = 2'($urandom);
    req_unsigned = 1'($urandom);
    cyc = 0; done = 0; lat = -1; reads = 0; rsp_pend = 0; secs = 2'b00;
    rd_w = srd; rsp_w = srsp; out_w = sout; rr_ok = 1; stable_ok = 1;
    held = '0; held_err = 0; rsp_cur = '0;
    while (!done && cyc < 300) begin
      cyc++;
      if (obs_rr(sel)) rr_ok = 0;
      if (obs_rdv(sel)) begin
        if (rd_w > 0) begin
          mem_rd_ready = 1'b0;
          rd_w--;
        end else begin
          mem_rd_ready = 1'b1;
          if (reads < 2) secs[reads] = obs_sec(sel);
          rsp_cur = obs_sec(sel) ? w1 : w0;
          reads++;
          rsp_pend = 1;
          rsp_w = srsp;
          rd_w = srd;
        end
        mem_rsp_valid = 1'($urandom);
        mem_rsp_data = {$urandom, $urandom};
      end else begin
        mem_rd_ready = 1'($urandom);
        if (rsp_pend) begin
          if (rsp_w > 0) begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data = {$urandom, $urandom};
            rsp_w--;
          end else begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data = rsp_cur;
            rsp_pend = 0;
          end
        end else begin
          mem_rsp_valid = 1'($urandom);
          mem_rsp_data = {$urandom, $urandom};
        end
      end
      if (obs_ov(sel)) begin
        if (lat < 0) begin
          lat = cyc;
          held = obs_od(sel);
          held_err = obs_err(sel);
        end else if (obs_od(sel) !== held || obs_err(sel) !== held_err) begin
          stable_ok = 0;
        end
        if (out_w > 0) begin
          out_ready = 1'b0;
          out_w--;
        end else begin
          out_ready = 1'b1;
          done = 1;
        end
      end else begin
        out_ready = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    mem_rd_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    out_ready = 1'b0;
    exp_lat = exp_e ? 1 : ((exp_reads == 2) ? 5 : 3) + exp_reads * (srd + srsp);
    check({tag, "_completed"}, 64'(done), 64'd1);
    check({tag, "_data"}, held, exp_d);
    check({tag, "_err"}, 64'(held_err), 64'(exp_e));
    check({tag, "_reads"}, 64'(reads), 64'(exp_reads));
    if (exp_reads >= 1) check({tag, "_second0"}, 64'(secs[0]), 64'd0);
    if (exp_reads == 2) check({tag, "_second1"}, 64'(secs[1]), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_total"}, 64'(cyc), 64'(exp_lat + sout));
    check({tag, "_busy"}, 64'(rr_ok), 64'd1);
    check({tag, "_stable"}, 64'(stable_ok), 64'd1);
    check({tag, "_ready_after"}, 64'(obs_rr(sel)), 64'd1);
    check({tag, "_ovalid_after"}, 64'(obs_ov(sel)), 64'd0);
    $display("%s: dw=%0d off=%0d size=%0d zext=%0d data=0x%0h err=%0d reads=%0d lat=%0d",
             tag, sel ? 64 : 32, off, size, zext, held, held_err, reads, lat);
  endtask

  task automatic check_reset_outputs(input bit sel, input string tag);
    check({tag, "_req_ready"}, 64'(obs_rr(sel)), 64'd1);
    check({tag, "_rd_valid"}, 64'(obs_rdv(sel)), 64'd0);
    check({tag, "_rd_second"}, 64'(obs_sec(sel)), 64'd0);
    check({tag, "_out_valid"}, 64'(obs_ov(sel)), 64'd0);
    check({tag, "_out_data"}, obs_od(sel), 64'd0);
    check({tag, "_out_err"}, 64'(obs_err(sel)), 64'd0);
  endtask

  task automatic reset_mid_load();
    req_unsigned = 1'b0;
`ifdef MISALIGN_EN
    req_off = 3'd3;
    req_size = 2'd1;
`else
    req_off = 3'd0;
    req_size = 2'd2;
`endif
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    mem_rd_ready = 1'b1;
    @(posedge clk); #1;
`ifdef MISALIGN_EN
    mem_rd_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = {$urandom, $urandom};
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    mem_rd_ready = 1'b1;
    @(posedge clk); #1;
`endif
    mem_rd_ready = 1'b0;
    check("rst_mid_busy", 64'(req_ready_a), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs(1'b0, "rst_mid");
    rst_n = 1'b1;
    $display("rst_mid: reset asserted while waiting on a response");
    run_load(1'b0, 0, 2, 1'($urandom), {32'h0, $urandom}, {32'h0, $urandom}, 0, 0, 0, "post_rst_word");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, off, size;
    logic [63:0] w0, w1;
    rst_n = 1'b0;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_off = '0; req_size = '0; req_unsigned = 1'b0;
    mem_rd_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(1'b0, "reset32");
    check_reset_outputs(1'b1, "reset64");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_load(1'b0, 2, 0, 1'b1, 64'h12F45678, 64'h0, 0, 0, 0, "byte_off2_u");
    run_load(1'b0, 2, 1, 1'b0, 64'h80011234, 64'h0, 0, 0, 0, "half_off2_s");
    run_load(1'b0, 2, 1, 1'b1, 64'h80011234, 64'h0, 0, 0, 0, "half_off2_u");
    run_load(1'b1, 0, 3, 1'b0, 64'h8000_0000_0000_0001, 64'h0, 0, 0, 0, "dword_pass");
    run_load(1'b0, 0, 3, 1'b0, 64'hDEADBEEF, 64'h0, 0, 0, 0, "illegal_d32");
    run_load(1'b0, 3, 1, 1'b0, 64'hAB000000, 64'h000000FF, 0, 0, 0, "half_off3_split");
    run_load(1'b1, 5, 2, 1'b0, 64'h89AB_CDEF_0123_4567, 64'h0000_0000_0000_00F1, 0, 0, 0, "word_off5_split64");
    run_load(1'b0, 1, 0, 1'b0, 64'h0000A500, 64'h0, 3, 2, 5, "bp_aligned");
    run_load(1'b0, 2, 2, 1'b1, 64'h11223344, 64'h55667788, 3, 2, 5, "bp_split");
    run_load(1'b0, 0, 2, 1'b0, 64'h87654321, 64'h0, 0, 0, 0, "word_pass32");

    reset_mid_load();

    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 1));
      off = int'($urandom_range(0, sel ? 7 : 3));
      size = int'($urandom_range(0, 3));
      w0 = sel ? {$urandom, $urandom} : {32'h0, $urandom};
      w1 = sel ? {$urandom, $urandom} : {32'h0, $urandom};
      run_load(sel[0], off, size, 1'($urandom), w0, w1,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
